show_rect_draw_engine: RTL and testbench
========================================

Name: show_rect_draw_engine

Overview:
- Consumer side of the overlay command stream: takes one rectangle-outline or row-clear command and rasterises it into pixel writes on the overlay RAM write port, one pixel per clock.
- Sits between the overlay controller, which issues commands once per command slot, and the dual-bank overlay RAM that the HDMI side reads.
- Worst-case command (full 256x256 outline, 1020 writes) completes inside the 2048-cycle rect slot.

Parameters:
- L_W, `LETTER_PIXEL_WIDTH (8), coordinate width in overlay pixels.
- X_MAX, 255, largest legal x; larger inputs are clamped.
- Y_MAX, 255, largest legal y; larger inputs are clamped.
- CLR_COLOR, 3'b000, colour written by clear commands.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- i_rect_start  in  1  one-cycle pulse requesting an outline draw.
- i_x1  in  L_W  rect corner A x.
- i_y1  in  L_W  rect corner A y.
- i_x2  in  L_W  rect corner B x.
- i_y2  in  L_W  rect corner B y.
- i_color  in  3  rect colour.
- i_clr_start  in  1  one-cycle pulse requesting a row clear.
- i_ys  in  L_W  clear first row.
- i_ye  in  L_W  clear last row.
- i_bank  in  1  target RAM half; becomes the address MSB.
- o_wr_en  out  1  RAM write strobe.
- o_wr_addr  out  2*L_W+1  {bank, y, x}.
- o_wr_data  out  3  pixel colour.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle pulse when a command finishes.
- o_drop  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: state IDLE; o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_drop all 0. Reset mid-command aborts at the next edge; no o_done is issued.
- States: IDLE, TOP, BOT, LEFT, RIGHT, CLR, DONE.
- Acceptance: a start is accepted only in IDLE.
  - Command fields and i_bank are latched at acceptance.
  - Coordinates are clamped to X_MAX/Y_MAX, then normalised: x_lo=min(x1,x2), x_hi=max; same for y. i_ys/i_ye are normalised the same way.
  - If both starts arrive in the same cycle, clear wins: the rect is dropped and o_drop pulses.
  - Any start while busy is ignored and o_drop pulses in the following cycle.
- Latency: acceptance at edge 0 gives the first write at edge 1. All outputs are registered. Exactly one write per cycle until the command finishes, with no bubble cycles.
- TOP: y=y_lo, x runs x_lo..x_hi.
- BOT: y=y_hi, x runs x_lo..x_hi. Skipped if y_lo==y_hi.
- LEFT: x=x_lo, y runs y_lo+1..y_hi-1. Skipped if y_hi-y_lo<2.
- RIGHT: x=x_hi, y runs y_lo+1..y_hi-1. Skipped if y_hi-y_lo<2 or x_lo==x_hi.
- Skip transitions go straight to the next non-empty edge in the same cycle, with no idle write slot.
- Rect write count = 2W + 2(H-2) for W>1 and H>1 (W=x_hi-x_lo+1, H=y_hi-y_lo+1). Degenerate cases:
  - Single pixel: 1 write.
  - Horizontal line: W writes.
  - Vertical line: H writes.
- CLR: rows ys..ye, x 0..X_MAX within each row (row-major), data CLR_COLOR. Write count = (ye-ys+1)*(X_MAX+1).
- DONE: one cycle with o_wr_en=0 and o_done=1, then IDLE.
  - o_busy is high from the first write cycle through DONE inclusive.
  - A new start is accepted in the cycle after DONE.
- Width rules:
  - Counters are L_W+1 bits so that x_hi=X_MAX terminates without wrap.
  - Address = {bank, y[L_W-1:0], x[L_W-1:0]}.
  - No arithmetic wraps: y_lo+1 and y_hi-1 are evaluated only when y_hi-y_lo>=2.
- While o_wr_en=0, o_wr_addr and o_wr_data hold their last value.

Decomposition:
- Shared overlay package/define file holds: state encoding, X_MAX/Y_MAX defaults, CLR_COLOR, and colour constants (3'b010 green, 3'b011 yellow).
- One natural sub-module: show_line_stepper (start/end/fixed coordinate, axis select; emits one coordinate per cycle plus a last flag), instanced once and reused for every edge and clear row.

Test Plan:
- Rect (10,20)-(19,24), colour 3'b011, bank 1:
  - 26 writes on edges 1-26: top x10..19 @y20, bottom @y24, left x10 y21..23, right x19 y21..23.
  - o_done at edge 27; first address {1,20,10}=0x1140A.
- Swapped corners (19,24)-(10,20) -> identical write sequence to the previous case.
- Degenerate cases:
  - (5,5)-(5,5) -> 1 write at 0x00505, then done.
  - (3,7)-(3,9) -> 3 writes x3 y7..9.
  - (0,2)-(4,2) -> 5 writes.
- Clear ys=1, ye=0, bank 0 -> 512 writes: row 0 x0..255, then row 1, data 0, addresses 0x00000..0x001FF; o_done at edge 513.
- Start collisions:
  - Simultaneous rect+clear start -> clear executes and o_drop pulses once.
  - Rect start while busy -> o_drop pulses and the running command is unaffected.
- Clamp and reset:
  - Rect (250,250)-(300-equivalent clamp case via X_MAX=200) -> x_hi=200, no address above x=200.
  - sys_rst asserted mid-TOP -> o_wr_en=0 next edge, no o_done; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/show_rect_draw_engine_pkg.sv
// show_rect_draw_engine_pkg: shared overlay types, state encoding and colour constants.
package show_rect_draw_engine_pkg;
   localparam int L_W = 8;
   localparam logic [L_W-1:0] X_MAX_DEF = 8'd255;
   localparam logic [L_W-1:0] Y_MAX_DEF = 8'd255;
   localparam logic [2:0] CLR_COLOR    = 3'b000;
   localparam logic [2:0] COLOR_GREEN  = 3'b010;
   localparam logic [2:0] COLOR_YELLOW = 3'b011;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TOP   = 3'd1;
   localparam logic [2:0] S_BOT   = 3'd2;
   localparam logic [2:0] S_LEFT  = 3'd3;
   localparam logic [2:0] S_RIGHT = 3'd4;
   localparam logic [2:0] S_CLR   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   typedef enum logic {AX_X, AX_Y} axis_e;
   typedef struct packed {
      logic [L_W-1:0] first;
      logic [L_W-1:0] last;
      logic [L_W-1:0] fix;
      axis_e          axis;
   } line_t;
   function automatic logic [L_W-1:0] clamp(input logic [L_W-1:0] v, input logic [L_W-1:0] m);
      return v > m ? m : v;
   endfunction
endpackage

// File: rtl/show_rect_draw_engine_if.sv
// show_rect_draw_engine_if: command inputs and RAM write port of the overlay draw engine.
interface show_rect_draw_engine_if;
   import show_rect_draw_engine_pkg::*;
   logic           i_rect_start;
   logic [L_W-1:0] i_x1;
   logic [L_W-1:0] i_y1;
   logic [L_W-1:0] i_x2;
   logic [L_W-1:0] i_y2;
   logic [2:0]     i_color;
   logic           i_clr_start;
   logic [L_W-1:0] i_ys;
   logic [L_W-1:0] i_ye;
   logic           i_bank;
   logic           o_wr_en;
   logic [2*L_W:0] o_wr_addr;
   logic [2:0]     o_wr_data;
   logic           o_busy;
   logic           o_done;
   logic           o_drop;
   modport master (
      output i_rect_start, i_x1, i_y1, i_x2, i_y2, i_color, i_clr_start, i_ys, i_ye, i_bank,
      input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_drop
   );
   modport slave (
      input  i_rect_start, i_x1, i_y1, i_x2, i_y2, i_color, i_clr_start, i_ys, i_ye, i_bank,
      output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_drop
   );
endinterface

// File: rtl/show_line_stepper.sv
// show_line_stepper: walks one coordinate from first to last along an axis, the other held fixed.
module show_line_stepper
   import show_rect_draw_engine_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic           step_i,
   input  line_t          line_i,
   output logic [L_W-1:0] x_o,
   output logic [L_W-1:0] y_o,
   output logic           last_o
);
   logic [L_W:0]   cur_q, cur_d;
   logic [L_W-1:0] end_q, end_d, fix_q, fix_d;
   axis_e          axis_q, axis_d;
   always_comb begin
      cur_d  = load_i ? {1'b0, line_i.first} : step_i ? cur_q + 1'b1 : cur_q;
      end_d  = load_i ? line_i.last : end_q;
      fix_d  = load_i ? line_i.fix : fix_q;
      axis_d = load_i ? line_i.axis : axis_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= '0;
         end_q  <= '0;
         fix_q  <= '0;
         axis_q <= AX_X;
      end else begin
         cur_q  <= cur_d;
         end_q  <= end_d;
         fix_q  <= fix_d;
         axis_q <= axis_d;
      end
   end
   // one extra counter bit keeps an end of X_MAX from wrapping back to zero
   assign last_o = cur_q == {1'b0, end_q};
   assign x_o    = axis_q == AX_Y ? fix_q : cur_q[L_W-1:0];
   assign y_o    = axis_q == AX_Y ? cur_q[L_W-1:0] : fix_q;
endmodule

// File: rtl/show_rect_draw_engine.sv
// show_rect_draw_engine: rasterises rectangle outlines and row clears into one overlay RAM write per clock.
module show_rect_draw_engine
   import show_rect_draw_engine_pkg::*;
#(
   parameter logic [L_W-1:0] X_MAX = X_MAX_DEF,
   parameter logic [L_W-1:0] Y_MAX = Y_MAX_DEF
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   show_rect_draw_engine_if.slave  bus
);
   logic [2:0]     state_q, state_d;
   logic [L_W-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d, y_hi_q, y_hi_d;
   logic [2:0]     color_q, color_d;
   logic           bank_q, bank_d;
   logic [L_W-1:0] cx1, cx2, cy1, cy2, cys, cye;
   logic [L_W-1:0] a_xlo, a_xhi, a_ylo, a_yhi, c_ylo, c_yhi;
   logic           idle, clr_go, rect_go, ld, stp, wr, drop, tall;
   line_t          ln;
   logic [L_W-1:0] sx, sy;
   logic           last;
   show_line_stepper u_step (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .load_i(ld),
      .step_i(stp),
      .line_i(ln),
      .x_o   (sx),
      .y_o   (sy),
      .last_o(last)
   );
   always_comb begin
      cx1     = clamp(bus.i_x1, X_MAX);
      cx2     = clamp(bus.i_x2, X_MAX);
      cy1     = clamp(bus.i_y1, Y_MAX);
      cy2     = clamp(bus.i_y2, Y_MAX);
      cys     = clamp(bus.i_ys, Y_MAX);
      cye     = clamp(bus.i_ye, Y_MAX);
      a_xlo   = cx1 < cx2 ? cx1 : cx2;
      a_xhi   = cx1 < cx2 ? cx2 : cx1;
      a_ylo   = cy1 < cy2 ? cy1 : cy2;
      a_yhi   = cy1 < cy2 ? cy2 : cy1;
      c_ylo   = cys < cye ? cys : cye;
      c_yhi   = cys < cye ? cye : cys;
      idle    = state_q == S_IDLE;
      clr_go  = idle & bus.i_clr_start;
      rect_go = idle & bus.i_rect_start & ~bus.i_clr_start;
      drop    = (~idle & (bus.i_rect_start | bus.i_clr_start)) | (idle & bus.i_rect_start & bus.i_clr_start);
      tall    = (y_hi_q - y_lo_q) >= L_W'(2);
   end
   always_comb begin
      state_d = state_q;
      x_lo_d  = x_lo_q;
      x_hi_d  = x_hi_q;
      y_lo_d  = y_lo_q;
      y_hi_d  = y_hi_q;
      color_d = color_q;
      bank_d  = bank_q;
      ld      = 1'b0;
      stp     = 1'b0;
      wr      = 1'b0;
      ln      = '0;
      if (clr_go) begin
         state_d = S_CLR;
         y_lo_d  = c_ylo;
         y_hi_d  = c_yhi;
         color_d = CLR_COLOR;
         bank_d  = bus.i_bank;
         ld      = 1'b1;
         ln      = '{'0, X_MAX, c_ylo, AX_X};
      end else if (rect_go) begin
         state_d = S_TOP;
         x_lo_d  = a_xlo;
         x_hi_d  = a_xhi;
         y_lo_d  = a_ylo;
         y_hi_d  = a_yhi;
         color_d = bus.i_color;
         bank_d  = bus.i_bank;
         ld      = 1'b1;
         ln      = '{a_xlo, a_xhi, a_ylo, AX_X};
      end else if (state_q == S_DONE || state_q > S_DONE) begin
         state_d = S_IDLE;
      end else if (!idle) begin
         wr  = 1'b1;
         stp = ~last;
         // on the last pixel of an edge, load the next non-empty edge so there is no gap cycle
         if (last) begin
            case (state_q)
               S_TOP: begin
                  state_d = y_lo_q != y_hi_q ? S_BOT : S_DONE;
                  ld      = y_lo_q != y_hi_q;
                  ln      = '{x_lo_q, x_hi_q, y_hi_q, AX_X};
               end
               S_BOT: begin
                  state_d = tall ? S_LEFT : S_DONE;
                  ld      = tall;
                  if (tall) ln = '{y_lo_q + 1'b1, y_hi_q - 1'b1, x_lo_q, AX_Y};
               end
               S_LEFT: begin
                  state_d = x_lo_q != x_hi_q ? S_RIGHT : S_DONE;
                  ld      = x_lo_q != x_hi_q;
                  ln      = '{y_lo_q + 1'b1, y_hi_q - 1'b1, x_hi_q, AX_Y};
               end
               S_CLR: begin
                  state_d = sy == y_hi_q ? S_DONE : S_CLR;
                  ld      = sy != y_hi_q;
                  if (sy != y_hi_q) ln = '{'0, X_MAX, sy + 1'b1, AX_X};
               end
               default: state_d = S_DONE;
            endcase
         end
      end
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= S_IDLE;
         x_lo_q        <= '0;
         x_hi_q        <= '0;
         y_lo_q        <= '0;
         y_hi_q        <= '0;
         color_q       <= '0;
         bank_q        <= 1'b0;
         bus.o_wr_en   <= 1'b0;
         bus.o_wr_addr <= '0;
         bus.o_wr_data <= '0;
         bus.o_busy    <= 1'b0;
         bus.o_done    <= 1'b0;
         bus.o_drop    <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_lo_q      <= x_lo_d;
         x_hi_q      <= x_hi_d;
         y_lo_q      <= y_lo_d;
         y_hi_q      <= y_hi_d;
         color_q     <= color_d;
         bank_q      <= bank_d;
         bus.o_wr_en <= wr;
         if (wr) begin
            bus.o_wr_addr <= {bank_q, sy, sx};
            bus.o_wr_data <= color_q;
         end
         bus.o_busy <= ~idle;
         bus.o_done <= state_q == S_DONE;
         bus.o_drop <= drop;
      end
   end
endmodule

// File: tb/tb_show_rect_draw_engine.sv
// tb_show_rect_draw_engine: scoreboard bench for the overlay draw engine, default and clamped instances.
module tb_show_rect_draw_engine;
   import show_rect_draw_engine_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   show_rect_draw_engine_if bus_a ();
   show_rect_draw_engine_if bus_b ();
   show_rect_draw_engine dut_a (.sys_clk(clk), .sys_rst(rst), .bus(bus_a));
   show_rect_draw_engine #(.X_MAX(8'd200), .Y_MAX(8'd200)) dut_b (.sys_clk(clk), .sys_rst(rst), .bus(bus_b));
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [19:0] q_a[$];
   logic [19:0] q_b[$];
   logic [19:0] e_a, e_b;
   int n_wr_a = 0, n_wr_b = 0, done_a = 0, done_b = 0, drop_a = 0;
   int first_cyc_a = 0, done_cyc_a = 0;
   logic [16:0] first_addr_a = '0;
   logic done_busy_a = 1'b0;
   logic [7:0] max_x_b = '0, max_y_b = '0;
   always @(posedge clk) cyc <= cyc + 1;
   // scoreboard: every observed write pops one expected {data, addr} entry
   always @(negedge clk) begin
      if (bus_a.o_wr_en === 1'b1) begin
         n_wr_a++;
         if (n_wr_a == 1) begin
            first_addr_a = bus_a.o_wr_addr;
            first_cyc_a  = cyc;
         end
         checks++;
         if (q_a.size() == 0) begin
            failures++;
            $display("FAIL wr_a extra write got=%h", {bus_a.o_wr_data, bus_a.o_wr_addr});
         end else begin
            e_a = q_a.pop_front();
            if ({bus_a.o_wr_data, bus_a.o_wr_addr} !== e_a) begin
               failures++;
               $display("FAIL wr_a got=%h exp=%h", {bus_a.o_wr_data, bus_a.o_wr_addr}, e_a);
            end
         end
      end
      if (bus_a.o_done === 1'b1) begin
         done_a++;
         done_cyc_a  = cyc;
         done_busy_a = bus_a.o_busy;
      end
      if (bus_a.o_drop === 1'b1) drop_a++;
      if (bus_b.o_wr_en === 1'b1) begin
         n_wr_b++;
         if (bus_b.o_wr_addr[7:0] > max_x_b) max_x_b = bus_b.o_wr_addr[7:0];
         if (bus_b.o_wr_addr[15:8] > max_y_b) max_y_b = bus_b.o_wr_addr[15:8];
         checks++;
         if (q_b.size() == 0) begin
            failures++;
            $display("FAIL wr_b extra write got=%h", {bus_b.o_wr_data, bus_b.o_wr_addr});
         end else begin
            e_b = q_b.pop_front();
            if ({bus_b.o_wr_data, bus_b.o_wr_addr} !== e_b) begin
               failures++;
               $display("FAIL wr_b got=%h exp=%h", {bus_b.o_wr_data, bus_b.o_wr_addr}, e_b);
            end
         end
      end
      if (bus_b.o_done === 1'b1) done_b++;
   end
   task automatic push_px(input bit which, input logic bank, input int y, input int x, input logic [2:0] c);
      logic [19:0] e;
      e = {c, bank, 8'(y), 8'(x)};
      if (which) q_b.push_back(e);
      else q_a.push_back(e);
   endtask
   task automatic push_rect(input bit which, input int x1, input int y1, input int x2, input int y2,
                            input logic [2:0] c, input logic bank, input int xm, input int ym);
      int xl, xh, yl, yh;
      x1 = x1 > xm ? xm : x1;
      x2 = x2 > xm ? xm : x2;
      y1 = y1 > ym ? ym : y1;
      y2 = y2 > ym ? ym : y2;
      xl = x1 < x2 ? x1 : x2;
      xh = x1 < x2 ? x2 : x1;
      yl = y1 < y2 ? y1 : y2;
      yh = y1 < y2 ? y2 : y1;
      for (int x = xl; x <= xh; x++) push_px(which, bank, yl, x, c);
      if (yl != yh) for (int x = xl; x <= xh; x++) push_px(which, bank, yh, x, c);
      for (int y = yl + 1; y <= yh - 1; y++) push_px(which, bank, y, xl, c);
      if (xl != xh) for (int y = yl + 1; y <= yh - 1; y++) push_px(which, bank, y, xh, c);
   endtask
   task automatic push_clear(input int ys, input int ye, input logic bank);
      int lo, hi;
      lo = ys < ye ? ys : ye;
      hi = ys < ye ? ye : ys;
      for (int y = lo; y <= hi; y++) for (int x = 0; x <= 255; x++) push_px(1'b0, bank, y, x, 3'b000);
   endtask
   task automatic go_rect(input int x1, input int y1, input int x2, input int y2,
                          input logic [2:0] c, input logic bank, output int s);
      @(negedge clk);
      bus_a.i_x1 = 8'(x1);
      bus_a.i_y1 = 8'(y1);
      bus_a.i_x2 = 8'(x2);
      bus_a.i_y2 = 8'(y2);
      bus_a.i_color = c;
      bus_a.i_bank = bank;
      bus_a.i_rect_start = 1'b1;
      s = cyc;
      n_wr_a = 0;
      @(negedge clk);
      bus_a.i_rect_start = 1'b0;
   endtask
   task automatic go_clear(input int ys, input int ye, input logic bank, input logic also_rect, output int s);
      @(negedge clk);
      bus_a.i_ys = 8'(ys);
      bus_a.i_ye = 8'(ye);
      bus_a.i_bank = bank;
      bus_a.i_clr_start = 1'b1;
      bus_a.i_rect_start = also_rect;
      s = cyc;
      n_wr_a = 0;
      @(negedge clk);
      bus_a.i_clr_start = 1'b0;
      bus_a.i_rect_start = 1'b0;
   endtask
   task automatic wait_done(input bit which, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((which ? bus_b.o_done : bus_a.o_done) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus_a.o_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus_a.o_wr_en); end
      checks++; if (bus_a.o_wr_addr !== 17'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus_a.o_wr_addr); end
      checks++; if (bus_a.o_wr_data !== 3'b0) begin failures++; $display("FAIL reset_data got=%b exp=0", bus_a.o_wr_data); end
      checks++; if (bus_a.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.o_busy); end
      checks++; if (bus_a.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.o_done); end
      checks++; if (bus_a.o_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", bus_a.o_drop); end
      rst = 1'b0;
   endtask
   task automatic test_rect(input bit swapped);
      int s;
      bit ok;
      push_rect(1'b0, 10, 20, 19, 24, 3'b011, 1'b1, 255, 255);
      if (swapped) go_rect(19, 24, 10, 20, 3'b011, 1'b1, s);
      else go_rect(10, 20, 19, 24, 3'b011, 1'b1, s);
      wait_done(1'b0, 3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rect_timeout swapped=%0d got=0 exp=1", swapped); end
      checks++; if (n_wr_a != 26) begin failures++; $display("FAIL rect_count got=%0d exp=26", n_wr_a); end
      checks++; if (first_addr_a !== 17'h1140A) begin failures++; $display("FAIL rect_first_addr got=%h exp=1140a", first_addr_a); end
      checks++; if (first_cyc_a != s + 2) begin failures++; $display("FAIL rect_first_edge got=%0d exp=%0d", first_cyc_a, s + 2); end
      checks++; if (done_cyc_a != s + 28) begin failures++; $display("FAIL rect_done_edge got=%0d exp=%0d", done_cyc_a, s + 28); end
      checks++; if (done_busy_a !== 1'b1) begin failures++; $display("FAIL rect_busy_at_done got=%b exp=1", done_busy_a); end
      checks++; if (q_a.size() != 0) begin failures++; $display("FAIL rect_missing got=%0d exp=0", q_a.size()); end
   endtask
   task automatic test_degenerate();
      int tbl[3][6] = '{'{5, 5, 5, 5, 1, 'h00505}, '{3, 7, 3, 9, 3, 'h00703}, '{0, 2, 4, 2, 5, 'h00200}};
      int s;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         push_rect(1'b0, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], COLOR_GREEN, 1'b0, 255, 255);
         go_rect(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], COLOR_GREEN, 1'b0, s);
         wait_done(1'b0, 100, ok);
         checks++; if (!ok) begin failures++; $display("FAIL degen_timeout case=%0d got=0 exp=1", i); end
         checks++; if (n_wr_a != tbl[i][4]) begin failures++; $display("FAIL degen_count case=%0d got=%0d exp=%0d", i, n_wr_a, tbl[i][4]); end
         checks++; if (first_addr_a !== 17'(tbl[i][5])) begin failures++; $display("FAIL degen_first case=%0d got=%h exp=%h", i, first_addr_a, tbl[i][5]); end
         checks++; if (q_a.size() != 0) begin failures++; $display("FAIL degen_missing case=%0d got=%0d exp=0", i, q_a.size()); end
      end
   endtask
   task automatic test_clear();
      int s;
      bit ok;
      push_clear(1, 0, 1'b0);
      go_clear(1, 0, 1'b0, 1'b0, s);
      wait_done(1'b0, 1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL clear_timeout got=0 exp=1"); end
      checks++; if (n_wr_a != 512) begin failures++; $display("FAIL clear_count got=%0d exp=512", n_wr_a); end
      checks++; if (first_addr_a !== 17'h0) begin failures++; $display("FAIL clear_first got=%h exp=0", first_addr_a); end
      checks++; if (done_cyc_a != s + 514) begin failures++; $display("FAIL clear_done_edge got=%0d exp=%0d", done_cyc_a, s + 514); end
      checks++; if (q_a.size() != 0) begin failures++; $display("FAIL clear_missing got=%0d exp=0", q_a.size()); end
   endtask
   task automatic test_collision();
      int s, d;
      bit ok;
      d = drop_a;
      bus_a.i_x1 = 8'd1; bus_a.i_y1 = 8'd1; bus_a.i_x2 = 8'd9; bus_a.i_y2 = 8'd9;
      push_clear(5, 5, 1'b1);
      go_clear(5, 5, 1'b1, 1'b1, s);
      wait_done(1'b0, 500, ok);
      checks++; if (!ok) begin failures++; $display("FAIL collide_timeout got=0 exp=1"); end
      checks++; if (n_wr_a != 256) begin failures++; $display("FAIL collide_count got=%0d exp=256", n_wr_a); end
      checks++; if (drop_a - d != 1) begin failures++; $display("FAIL collide_drop got=%0d exp=1", drop_a - d); end
      checks++; if (q_a.size() != 0) begin failures++; $display("FAIL collide_missing got=%0d exp=0", q_a.size()); end
   endtask
   task automatic test_back_to_back_drop();
      int s, d;
      bit ok;
      d = drop_a;
      push_rect(1'b0, 10, 10, 50, 12, COLOR_GREEN, 1'b0, 255, 255);
      go_rect(10, 10, 50, 12, COLOR_GREEN, 1'b0, s);
      repeat (3) @(negedge clk);
      bus_a.i_x1 = 8'd200; bus_a.i_y1 = 8'd100; bus_a.i_color = 3'b111; bus_a.i_bank = 1'b1;
      bus_a.i_rect_start = 1'b1;
      @(negedge clk);
      bus_a.i_rect_start = 1'b0;
      wait_done(1'b0, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL busy_timeout got=0 exp=1"); end
      checks++; if (drop_a - d != 1) begin failures++; $display("FAIL busy_drop got=%0d exp=1", drop_a - d); end
      checks++; if (n_wr_a != 84) begin failures++; $display("FAIL busy_count got=%0d exp=84", n_wr_a); end
      checks++; if (q_a.size() != 0) begin failures++; $display("FAIL busy_missing got=%0d exp=0", q_a.size()); end
   endtask
   task automatic test_clamp();
      bit ok;
      push_rect(1'b1, 250, 250, 180, 190, COLOR_YELLOW, 1'b0, 200, 200);
      @(negedge clk);
      n_wr_b = 0; max_x_b = '0; max_y_b = '0;
      bus_b.i_x1 = 8'd250; bus_b.i_y1 = 8'd250; bus_b.i_x2 = 8'd180; bus_b.i_y2 = 8'd190;
      bus_b.i_color = COLOR_YELLOW; bus_b.i_bank = 1'b0; bus_b.i_rect_start = 1'b1;
      @(negedge clk);
      bus_b.i_rect_start = 1'b0;
      wait_done(1'b1, 300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL clamp_timeout got=0 exp=1"); end
      checks++; if (n_wr_b != 60) begin failures++; $display("FAIL clamp_count got=%0d exp=60", n_wr_b); end
      checks++; if (max_x_b !== 8'd200) begin failures++; $display("FAIL clamp_max_x got=%0d exp=200", max_x_b); end
      checks++; if (max_y_b !== 8'd200) begin failures++; $display("FAIL clamp_max_y got=%0d exp=200", max_y_b); end
      checks++; if (q_b.size() != 0) begin failures++; $display("FAIL clamp_missing got=%0d exp=0", q_b.size()); end
   endtask
   task automatic test_reset_mid();
      int s, d;
      bit ok;
      push_rect(1'b0, 0, 0, 100, 100, COLOR_GREEN, 1'b0, 255, 255);
      go_rect(0, 0, 100, 100, COLOR_GREEN, 1'b0, s);
      repeat (5) @(negedge clk);
      d = done_a;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus_a.o_wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en got=%b exp=0", bus_a.o_wr_en); end
      checks++; if (bus_a.o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus_a.o_busy); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (done_a != d) begin failures++; $display("FAIL rstmid_done got=%0d exp=%0d", done_a, d); end
      checks++; if (bus_a.o_wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_idle_wr got=%b exp=0", bus_a.o_wr_en); end
      q_a.delete();
      push_rect(1'b0, 5, 5, 6, 6, COLOR_YELLOW, 1'b1, 255, 255);
      go_rect(6, 6, 5, 5, COLOR_YELLOW, 1'b1, s);
      wait_done(1'b0, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_fresh_timeout got=0 exp=1"); end
      checks++; if (n_wr_a != 4) begin failures++; $display("FAIL rstmid_fresh_count got=%0d exp=4", n_wr_a); end
      checks++; if (q_a.size() != 0) begin failures++; $display("FAIL rstmid_fresh_missing got=%0d exp=0", q_a.size()); end
   endtask
   initial begin
      bus_a.i_rect_start = 1'b0; bus_a.i_clr_start = 1'b0; bus_a.i_bank = 1'b0; bus_a.i_color = 3'b0;
      bus_a.i_x1 = '0; bus_a.i_y1 = '0; bus_a.i_x2 = '0; bus_a.i_y2 = '0; bus_a.i_ys = '0; bus_a.i_ye = '0;
      bus_b.i_rect_start = 1'b0; bus_b.i_clr_start = 1'b0; bus_b.i_bank = 1'b0; bus_b.i_color = 3'b0;
      bus_b.i_x1 = '0; bus_b.i_y1 = '0; bus_b.i_x2 = '0; bus_b.i_y2 = '0; bus_b.i_ys = '0; bus_b.i_ye = '0;
      test_reset();
      test_rect(1'b0);
      test_rect(1'b1);
      test_degenerate();
      test_clear();
      test_collision();
      test_back_to_back_drop();
      test_clamp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
